// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared types and constants for the up/down modulo counter:
//               mode constants and the command enum used by priority decode.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // Overflow handling mode, sampled on the sat input
  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

  // Winning command after priority decode (clr > ld > count)
  typedef enum logic [2:0] {
    CMD_HOLD = 3'd0,
    CMD_UP   = 3'd1,
    CMD_DN   = 3'd2,
    CMD_LD   = 3'd3,
    CMD_CLR  = 3'd4
  } cmd_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_step_alu.sv
`default_nettype none
// ============================================================================
// Module      : counter_step_alu
// Description : Combinational step arithmetic for the modulo counter. Clamps
//               the step to MAX, then adds or subtracts it with wrap or
//               saturate behaviour and flags crossings of MAX / 0.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_step_alu
  import counter_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int unsigned MODULUS = 2**WIDTH
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic             dir_up_i,
  input  logic             sat_i,
  output logic [WIDTH-1:0] next_o,
  output logic             ovf_nxt_o,
  output logic             unf_nxt_o
);

  localparam int unsigned      MAX_U  = MODULUS - 1;
  localparam logic [WIDTH-1:0] MAX_V  = MAX_U[WIDTH-1:0];
  // Low WIDTH bits of the modulus; wrapped results always fit in WIDTH bits,
  // so modulo-2**WIDTH arithmetic with this constant yields the exact value
  // (for MODULUS == 2**WIDTH the constant is zero, i.e. natural roll-over).
  localparam logic [WIDTH-1:0] MOD_LO = MODULUS[WIDTH-1:0];

  logic [WIDTH-1:0] s_eff;
  logic [WIDTH:0]   sum;

  // Clamp step, then compute the up/down result with wrap or saturation
  always_comb begin
    s_eff     = (step_i > MAX_V) ? MAX_V : step_i;
    sum       = {1'b0, q_i} + {1'b0, s_eff};
    next_o    = q_i;
    ovf_nxt_o = 1'b0;
    unf_nxt_o = 1'b0;
    if (dir_up_i) begin
      if (sum > {1'b0, MAX_V}) begin
        ovf_nxt_o = 1'b1;
        next_o    = (sat_i == CNT_SAT) ? MAX_V : (sum[WIDTH-1:0] - MOD_LO);
      end else begin
        next_o = sum[WIDTH-1:0];
      end
    end else begin
      if (s_eff <= q_i) begin
        next_o = q_i - s_eff;
      end else begin
        unf_nxt_o = 1'b1;
        next_o    = (sat_i == CNT_SAT) ? '0 : (q_i - s_eff + MOD_LO);
      end
    end
  end

endmodule : counter_step_alu
`default_nettype wire

// File: rtl/counter_ud_mod.sv
`default_nettype none
// ============================================================================
// Module      : counter_ud_mod
// Description : Parametrised up/down modulo counter with programmable step,
//               parallel load with clamp, wrap/saturate mode, terminal-count
//               outputs and one-cycle ovf/unf/ld_err pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_ud_mod
  import counter_pkg::*;
#(
  parameter int          WIDTH         = 8,
  parameter int unsigned MODULUS       = 2**WIDTH,
  parameter int unsigned INITIAL_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             c_up,
  input  logic             c_dn,
  input  logic [WIDTH-1:0] step,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             tc_up,
  output logic             tc_dn,
  output logic             ovf,
  output logic             unf,
  output logic             ld_err
);

  localparam int unsigned      MAX_U  = MODULUS - 1;
  localparam logic [WIDTH-1:0] MAX_V  = MAX_U[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INIT_V = INITIAL_VALUE[WIDTH-1:0];

  // Reject illegal parameter combinations at elaboration
  if ((WIDTH < 2) || (MODULUS < 2) || (MODULUS > 2**WIDTH) ||
      (INITIAL_VALUE > MODULUS - 1)) begin : g_bad_params
    $fatal(1, "counter_ud_mod: illegal WIDTH/MODULUS/INITIAL_VALUE");
  end

  cmd_e             cmd;
  logic [WIDTH-1:0] alu_next;
  logic             alu_ovf;
  logic             alu_unf;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ld_err_q, ld_err_d;

  // Priority decode: clr > ld > single-direction count; both/neither hold
  always_comb begin
    cmd = CMD_HOLD;
    if (clr)                cmd = CMD_CLR;
    else if (ld)            cmd = CMD_LD;
    else if (c_up && !c_dn) cmd = CMD_UP;
    else if (c_dn && !c_up) cmd = CMD_DN;
  end

  counter_step_alu #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_alu (
    .q_i       (q_q),
    .step_i    (step),
    .dir_up_i  (cmd == CMD_UP),
    .sat_i     (sat),
    .next_o    (alu_next),
    .ovf_nxt_o (alu_ovf),
    .unf_nxt_o (alu_unf)
  );

  // Next-state selection; flags default low so each event pulses one cycle
  always_comb begin
    q_d      = q_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    ld_err_d = 1'b0;
    case (cmd)
      CMD_CLR: q_d = INIT_V;
      CMD_LD: begin
        if (d > MAX_V) begin
          q_d      = MAX_V;
          ld_err_d = 1'b1;
        end else begin
          q_d = d;
        end
      end
      CMD_UP: begin
        q_d   = alu_next;
        ovf_d = alu_ovf;
      end
      CMD_DN: begin
        q_d   = alu_next;
        unf_d = alu_unf;
      end
      default: q_d = q_q;
    endcase
  end

  // State and flag registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q_q      <= INIT_V;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign q      = q_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign ld_err = ld_err_q;
  assign tc_up  = (q_q == MAX_V);
  assign tc_dn  = (q_q == '0);

endmodule : counter_ud_mod
`default_nettype wire

// File: doc/counter_ud_mod.md
# counter_ud_mod

Parametrised up/down modulo counter, successor to the laboratory 8-bit up-counter. Adds:
- programmable modulus;
- variable step;
- down counting;
- parallel load;
- selectable wrap or saturate mode;
- terminal-count and overflow/underflow flags.

It serves as the general event/address counter for datapath and timer blocks in later labs.

## Interface
Parameters:
- WIDTH, 8, counter and data width (≥2)
- MODULUS, 2**WIDTH, count range is 0..MODULUS-1; must satisfy 2 ≤ MODULUS ≤ 2**WIDTH
- INITIAL_VALUE, 0, value after reset/clr; must be ≤ MODULUS-1 (elaboration-time check, fatal otherwise)

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_b  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear to INITIAL_VALUE
- ld  in  1  synchronous parallel load of d
- d  in  WIDTH  load value
- c_up  in  1  count up by step
- c_dn  in  1  count down by step
- step  in  WIDTH  increment magnitude
- sat  in  1  mode: 0 = wrap modulo MODULUS, 1 = saturate at 0 / MAX
- q  out  WIDTH  counter value
- tc_up  out  1  combinational, q == MAX (MAX = MODULUS-1)
- tc_dn  out  1  combinational, q == 0
- ovf  out  1  registered one-cycle pulse: an up-count crossed MAX
- unf  out  1  registered one-cycle pulse: a down-count crossed 0
- ld_err  out  1  registered one-cycle pulse: d > MAX on a load

## Operation
- Command priority, sampled each rising edge: rst_b (async) > clr > ld > count.
- **Count command:**
  - c_up & !c_dn: count up.
  - c_dn & !c_up: count down.
  - Both or neither: hold. No flags.
- **Step clamping:** effective step s = min(step, MAX). step == 0 with a count command is a hold; no flags.
- **Up count:** compute sum = q + s in WIDTH+1 bits.
  - sum ≤ MAX: q ← sum.
  - sum > MAX, wrap: q ← sum − MODULUS; ovf ← 1.
  - sum > MAX, sat: q ← MAX; ovf ← 1.
- **Down count:**
  - s ≤ q: q ← q − s.
  - s > q, wrap: q ← q + MODULUS − s; unf ← 1.
  - s > q, sat: q ← 0; unf ← 1.
- **Saturate with no move:** in sat mode at MAX with an up-count, q stays MAX and ovf still pulses (attempted crossing). Same for 0 with a down-count (unf pulses).
- **Load:** q ← d if d ≤ MAX. Otherwise q ← MAX and ld_err ← 1. A load never raises ovf/unf.
- **clr:** q ← INITIAL_VALUE. Flags 0.
- **Mode switching:** sat may change any cycle; it affects only the edge at which it is sampled.

## Timing
- **Reset:** async assert, while rst_b = 0:
  - q = INITIAL_VALUE;
  - ovf = unf = ld_err = 0;
  - tc_up/tc_dn reflect INITIAL_VALUE.
- **Reset release:** synchronous use; the first command is acted on at the first rising edge after rst_b = 1.
- **Reset mid-operation:** q returns to INITIAL_VALUE immediately, without waiting for a clock edge. Any pending flag pulse is cleared.
- **Latency:**
  - q, ovf, unf and ld_err update at the same edge that samples the command; 1-cycle latency from command to q.
  - Each flag is high for exactly one cycle per event.
  - Back-to-back overflowing commands give a continuous high flag, one cycle per event.
- **Terminal counts:** tc_up/tc_dn follow q combinationally, with no extra register stage.

## Structure
- **Shared package counter_pkg:**
  - mode constants CNT_WRAP = 1'b0, CNT_SAT = 1'b1;
  - cmd enum {CMD_HOLD, CMD_UP, CMD_DN, CMD_LD, CMD_CLR} used for priority decode.
- **Sub-module counter_step_alu** (purely combinational):
  - inputs: q, step, dir, sat;
  - outputs: next value, ovf_nxt, unf_nxt;
  - parametrised by WIDTH and MODULUS.
- **Top level:** priority decode, load clamp and the registers.

## Test plan
1. **Reset/clr:** WIDTH=8, MODULUS=10, INITIAL_VALUE=3.
   - Assert rst_b = 0 between edges → q = 3 immediately, flags 0.
   - clr after counting → q = 3 next edge.
2. **Wrap up:** q = 8, step = 3, c_up, sat = 0 → q = 1, ovf = 1 for one cycle. Repeat with q = 9, step = 1 → q = 0, ovf.
3. **Wrap down/saturate:** q = 2, step = 5, c_dn.
   - sat = 0 → q = 7, unf pulse.
   - Same with sat = 1 → q = 0, unf pulse.
   - Then a further c_dn at 0 → q = 0, unf pulses again.
4. **Priority/simultaneous:**
   - clr + ld + c_up in one cycle → q = INITIAL_VALUE.
   - ld + c_up with d = 5 → q = 5, no ovf.
   - c_up & c_dn → hold, no flags.
5. **Load clamp and step clamp:**
   - ld with d = 12 → q = 9, ld_err pulse, tc_up = 1.
   - From q = 0, step = 200 with c_up, sat = 1 → s clamped to 9 → q = 9, no ovf.
6. **Full-range default:** WIDTH=8, MODULUS=256.
   - q = 8'hFF, step = 1, c_up, sat = 0 → q = 8'h00 with ovf pulse (matches the old counter's roll-over).
